// File: rtl/blit_phrase_engine.sv
// 2-D phrase-mode fill/copy engine with GPU register file, bus request/grant master
// port, copy read buffer, per-row strides, abort and completion interrupt.
module blit_phrase_engine #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 24,
  parameter int CNT_W     = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic              sys_clk,
  input  logic              xreset_n,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [2:0]        reg_addr,
  input  logic [31:0]       reg_din,
  output logic [31:0]       gpu_dout_out,
  output logic              gpu_dout_oe,
  output logic              blit_breq,
  input  logic              blit_bgnt,
  output logic              mreq,
  output logic              mread,
  output logic [ADDR_W-1:0] maddr,
  output logic [DATA_W-1:0] mwdata,
  input  logic [DATA_W-1:0] mrdata,
  input  logic              mack,
  output logic              busy,
  output logic              blit_int
);

  localparam int INC  = DATA_W / 8;
  localparam int AL   = $clog2(INC);
  localparam int BI_W = $clog2(BUF_DEPTH);
  localparam int K_W  = BI_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_ROWEND = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_src, r_dst, r_sp, r_dp;
  logic [CNT_W-1:0]  r_inner, r_outer, r_inner_rem, r_outer_rem;
  logic [15:0]       r_sstride, r_dstride;
  logic [31:0]       r_fill_lo, r_fill_hi;
  logic              r_mode, r_int_en, r_err, r_stopped, r_abort, r_inflight;
  logic              r_dout_oe;
  logic [31:0]       r_dout;
  logic [BI_W-1:0]   r_bidx;
  logic [K_W-1:0]    r_k;
  logic [DATA_W-1:0] r_buf [BUF_DEPTH];

  logic [DATA_W-1:0] w_fill;
  logic [ADDR_W-1:0] w_addr, w_sstride, w_dstride;
  logic              w_cmd, w_stop, w_cfg_wr, w_abort, w_xfer_st, w_done_xfer;
  logic              w_last, w_zero;

  // Burst length for the next copy read phase.
  function automatic logic [K_W-1:0] f_burst(input logic [CNT_W-1:0] n);
    if (n > CNT_W'(BUF_DEPTH)) return K_W'(BUF_DEPTH);
    return K_W'(n);
  endfunction

  generate
    if (DATA_W == 64) begin : g_fill64
      assign w_fill = {r_fill_hi, r_fill_lo};
    end else begin : g_fill32
      assign w_fill = DATA_W'(r_fill_lo);
    end
  endgenerate

  assign w_cmd       = reg_wr && (reg_addr == 3'd6);
  assign w_stop      = reg_wr && (reg_addr == 3'd7) && busy;
  assign w_cfg_wr    = reg_wr && (reg_addr < 3'd6);
  assign w_abort     = r_abort || w_stop;
  assign w_xfer_st   = (r_state == S_READ) || (r_state == S_WRITE);
  assign w_zero      = (r_inner_rem == '0) || (r_outer_rem == '0);
  assign w_last      = ({1'b0, r_bidx} == (r_k - K_W'(1)));
  assign w_sstride   = {{(ADDR_W-16){r_sstride[15]}}, r_sstride};
  assign w_dstride   = {{(ADDR_W-16){r_dstride[15]}}, r_dstride};
  assign w_addr      = (r_state == S_READ) ? r_sp : r_dp;

  // A started transfer is held regardless of grant; a new one needs grant and no pending abort.
  assign mreq        = w_xfer_st && (r_inflight || (blit_bgnt && !r_abort));
  assign w_done_xfer = mreq && mack;
  assign mread       = mreq && (r_state == S_READ);
  assign maddr       = mreq ? {w_addr[ADDR_W-1:AL], {AL{1'b0}}} : '0;
  assign mwdata      = (mreq && !mread) ? (r_mode ? r_buf[r_bidx] : w_fill) : '0;

  assign busy         = (r_state != S_IDLE);
  assign blit_breq    = (r_state == S_READ) || (r_state == S_WRITE) || (r_state == S_ROWEND) ||
                        ((r_state == S_REQ) && !w_zero);
  assign blit_int     = (r_state == S_DONE) && r_int_en;
  assign gpu_dout_oe  = r_dout_oe;
  assign gpu_dout_out = r_dout;

  always_ff @(posedge sys_clk) begin
    if (!xreset_n) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_sp        <= '0;
      r_dp        <= '0;
      r_inner     <= '0;
      r_outer     <= '0;
      r_inner_rem <= '0;
      r_outer_rem <= '0;
      r_sstride   <= '0;
      r_dstride   <= '0;
      r_fill_lo   <= '0;
      r_fill_hi   <= '0;
      r_mode      <= 1'b0;
      r_int_en    <= 1'b0;
      r_err       <= 1'b0;
      r_stopped   <= 1'b0;
      r_abort     <= 1'b0;
      r_inflight  <= 1'b0;
      r_dout_oe   <= 1'b0;
      r_dout      <= '0;
      r_bidx      <= '0;
      r_k         <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_dout_oe  <= reg_rd;
      r_dout     <= reg_rd ? {busy, r_err, r_stopped, 13'b0, 16'(r_outer_rem)} : 32'h0;
      r_inflight <= mreq && !mack;
      if (reg_rd && (reg_addr == 3'd7)) begin
        r_err     <= 1'b0;
        r_stopped <= 1'b0;
      end
      if (busy && (w_cfg_wr || w_cmd)) r_err <= 1'b1;
      if (!busy && w_cfg_wr) begin
        case (reg_addr)
          3'd0:    r_src <= reg_din[ADDR_W-1:0];
          3'd1:    r_dst <= reg_din[ADDR_W-1:0];
          3'd2:    begin r_outer <= reg_din[16 +: CNT_W]; r_inner <= reg_din[CNT_W-1:0]; end
          3'd3:    begin r_dstride <= reg_din[31:16]; r_sstride <= reg_din[15:0]; end
          3'd4:    r_fill_lo <= reg_din;
          default: r_fill_hi <= reg_din;
        endcase
      end
      if (w_stop && (r_state != S_DONE)) r_abort <= 1'b1;

      case (r_state)
        S_IDLE: if (w_cmd) begin
          r_sp        <= r_src;
          r_dp        <= r_dst;
          r_inner_rem <= r_inner;
          r_outer_rem <= r_outer;
          r_mode      <= reg_din[0];
          r_int_en    <= reg_din[1];
          r_state     <= S_REQ;
        end
        S_REQ: begin
          if (w_zero || w_abort) r_state <= S_DONE;
          else if (blit_bgnt) begin
            r_k     <= f_burst(r_inner_rem);
            r_bidx  <= '0;
            r_state <= r_mode ? S_READ : S_WRITE;
          end
        end
        S_READ: begin
          if (w_done_xfer) begin
            r_buf[r_bidx] <= mrdata;
            r_sp          <= r_sp + ADDR_W'(INC);
            r_bidx        <= r_bidx + BI_W'(1);
            if (w_abort) r_state <= S_DONE;
            else if (w_last) begin
              r_bidx  <= '0;
              r_state <= S_WRITE;
            end
          end else if (!mreq && w_abort) r_state <= S_DONE;
        end
        S_WRITE: begin
          if (w_done_xfer) begin
            r_dp        <= r_dp + ADDR_W'(INC);
            r_inner_rem <= r_inner_rem - CNT_W'(1);
            r_bidx      <= r_bidx + BI_W'(1);
            if (w_abort) r_state <= S_DONE;
            else if (r_inner_rem == CNT_W'(1)) r_state <= S_ROWEND;
            else if (r_mode && w_last) begin
              r_bidx  <= '0;
              r_k     <= f_burst(r_inner_rem - CNT_W'(1));
              r_state <= S_READ;
            end
          end else if (!mreq && w_abort) r_state <= S_DONE;
        end
        S_ROWEND: begin
          if (w_abort) r_state <= S_DONE;
          else begin
            r_sp        <= r_sp + w_sstride;
            r_dp        <= r_dp + w_dstride;
            r_outer_rem <= r_outer_rem - CNT_W'(1);
            r_inner_rem <= r_inner;
            r_k         <= f_burst(r_inner);
            r_bidx      <= '0;
            if (r_outer_rem == CNT_W'(1)) r_state <= S_DONE;
            else r_state <= r_mode ? S_READ : S_WRITE;
          end
        end
        S_DONE: begin
          if (w_abort) r_stopped <= 1'b1;
          r_abort <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blit_phrase_engine.sv
// Randomized bench for blit_phrase_engine: memory/arbiter responder, bus monitor and a
// transaction-list reference model of fill/copy jobs.
module tb_blit_phrase_engine;
  localparam int DW = 64, AW = 24, BD = 4;

  logic          sys_clk = 1'b0, xreset_n = 1'b0, reg_wr = 1'b0, reg_rd = 1'b0;
  logic [2:0]    reg_addr = '0;
  logic [31:0]   reg_din = '0;
  logic [31:0]   gpu_dout_out;
  logic          gpu_dout_oe, blit_breq, mreq, mread, busy, blit_int;
  logic          blit_bgnt = 1'b0, mack = 1'b0;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata, mrdata = '0;

  blit_phrase_engine #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(16), .BUF_DEPTH(BD)) dut (
    .sys_clk(sys_clk), .xreset_n(xreset_n), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_din(reg_din), .gpu_dout_out(gpu_dout_out),
    .gpu_dout_oe(gpu_dout_oe), .blit_breq(blit_breq), .blit_bgnt(blit_bgnt),
    .mreq(mreq), .mread(mread), .maddr(maddr), .mwdata(mwdata), .mrdata(mrdata),
    .mack(mack), .busy(busy), .blit_int(blit_int));

  typedef struct {bit rd; logic [AW-1:0] a; logic [DW-1:0] d;} xfer_t;
  xfer_t expq[$], obsq[$];
  int n_chk = 0, n_fail = 0, n_int = 0, n_mreq = 0;
  int g_mode = 0, dly_lo = 1, dly_hi = 1, rsp_cnt = 0, rsp_dly = 1;
  bit mon_pend = 0, mon_rd = 0;
  logic [AW-1:0] mon_a;
  logic [DW-1:0] mon_d;

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
    return {8'h5A, a, 32'(a) * 32'h9E3779B1};
  endfunction

  // Arbiter and memory: grant only changes while no request is up; mack after a random delay.
  initial begin
    forever begin
      @(posedge sys_clk); #1;
      if (g_mode == 1 && !mreq) blit_bgnt = ($urandom_range(0, 3) != 0);
      #1;
      if (!xreset_n) begin
        mack = 1'b0; rsp_cnt = 0;
      end else begin
        if (mack) begin mack = 1'b0; rsp_cnt = 0; end
        if (mreq) begin
          if (rsp_cnt == 0) rsp_dly = $urandom_range(dly_lo, dly_hi);
          if (rsp_cnt >= rsp_dly) begin
            mack = 1'b1;
            mrdata = mread ? memfn(maddr) : '0;
          end else rsp_cnt++;
        end
      end
    end
  end

  initial begin
    xfer_t t;
    forever begin
      @(negedge sys_clk);
      if (!xreset_n) mon_pend = 0;
      else begin
        if (blit_int) n_int++;
        if (mreq) n_mreq++;
        if (mon_pend) begin
          chk("hold_mreq", mreq, 1);
          chk("hold_addr", maddr, mon_a);
          chk("hold_kind", mread, mon_rd);
          if (!mon_rd) chk("hold_wdata", mwdata, mon_d);
        end else if (mreq) chk("mreq_without_grant", blit_bgnt, 1);
        if (mreq && mack) begin
          t.rd = mread; t.a = maddr; t.d = mwdata;
          obsq.push_back(t);
        end
        mon_pend = mreq && !mack; mon_a = maddr; mon_d = mwdata; mon_rd = mread;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_din = d;
    @(posedge sys_clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic rd_stat(input logic [2:0] a, output logic [31:0] d);
    reg_rd = 1'b1; reg_addr = a;
    @(posedge sys_clk); #1;
    reg_rd = 1'b0;
    chk("read_oe", gpu_dout_oe, 1);
    d = gpu_dout_out;
  endtask

  // Reference: expected bus transaction list for a complete job.
  task automatic build_exp(input logic [AW-1:0] src, dst, input int inner, outer, sstr, dstr,
                           input logic [63:0] fill, input bit mode);
    logic [AW-1:0] sp, dp;
    int done, k;
    xfer_t t;
    expq.delete(); sp = src; dp = dst;
    if (inner == 0 || outer == 0) return;
    for (int r = 0; r < outer; r++) begin
      if (!mode) begin
        for (int i = 0; i < inner; i++) begin
          t.rd = 0; t.a = dp + AW'(8 * i); t.d = fill; expq.push_back(t);
        end
      end else begin
        done = 0;
        while (done < inner) begin
          k = (inner - done < BD) ? inner - done : BD;
          for (int j = 0; j < k; j++) begin
            t.rd = 1; t.a = sp + AW'(8 * (done + j)); t.d = '0; expq.push_back(t);
          end
          for (int j = 0; j < k; j++) begin
            t.rd = 0; t.a = dp + AW'(8 * (done + j)); t.d = memfn(sp + AW'(8 * (done + j)));
            expq.push_back(t);
          end
          done += k;
        end
      end
      sp = sp + AW'(8 * inner) + AW'(sstr);
      dp = dp + AW'(8 * inner) + AW'(dstr);
    end
  endtask

  task automatic start_job(input logic [AW-1:0] src, dst, input int inner, outer, sstr, dstr,
                           input logic [63:0] fill, input bit mode, input bit int_en);
    build_exp(src, dst, inner, outer, sstr, dstr, fill, mode);
    obsq.delete(); n_int = 0;
    wr(3'd0, 32'(src)); wr(3'd1, 32'(dst));
    wr(3'd2, {16'(outer), 16'(inner)}); wr(3'd3, {16'(dstr), 16'(sstr)});
    wr(3'd4, fill[31:0]); wr(3'd5, fill[63:32]);
    wr(3'd6, {30'b0, int_en, mode});
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 5000) begin cyc(1); k++; end
    chk({tag, " done_in_time"}, busy, 0);
  endtask

  task automatic check_job(input string tag, input bit int_en, input logic [31:0] exp_stat);
    logic [31:0] s;
    wait_idle(tag);
    chk({tag, " xfer_count"}, obsq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
      chk($sformatf("%s[%0d] kind", tag, i), obsq[i].rd, expq[i].rd);
      chk($sformatf("%s[%0d] addr", tag, i), obsq[i].a, expq[i].a);
      if (!expq[i].rd) chk($sformatf("%s[%0d] wdata", tag, i), obsq[i].d, expq[i].d);
    end
    chk({tag, " int_pulses"}, n_int, int_en ? 1 : 0);
    rd_stat(3'd0, s);
    chk({tag, " status"}, s, exp_stat);
  endtask

  initial begin
    logic [31:0] s;
    int k, m0, inner, outer;
    bit mode, ie;
    logic [63:0] fill;
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst mreq", mreq, 0);       chk("rst breq", blit_breq, 0);
    chk("rst busy", busy, 0);       chk("rst int", blit_int, 0);
    chk("rst oe", gpu_dout_oe, 0);  chk("rst dout", gpu_dout_out, 0);
    chk("rst maddr", maddr, 0);     chk("rst mwdata", mwdata, 0);
    xreset_n = 1'b1;
    cyc(1);
    rd_stat(3'd0, s); chk("rst status", s, 0);
    cyc(1); chk("read_oe_one_cycle", gpu_dout_oe, 0);

    // Fill with row stride.
    blit_bgnt = 1'b1; g_mode = 0; dly_lo = 1; dly_hi = 1;
    start_job(24'h0, 24'h1000, 3, 2, 0, 8, 64'hDEADBEEF_01234567, 0, 1);
    check_job("fill", 1, 32'h0);
    if (obsq.size() == 6) chk("fill last addr", obsq[5].a, 24'h1030);

    // Copy, burst split 4 + 2.
    start_job(24'h2000, 24'h3000, 6, 1, 0, 0, 64'h0, 1, 1);
    check_job("copy", 1, 32'h0);

    // Grant withheld, slow mack.
    blit_bgnt = 1'b0; dly_lo = 3; dly_hi = 3;
    start_job(24'h0, 24'h4000, 4, 1, 0, 0, 64'h1111_2222_3333_4444, 0, 0);
    chk("nogrant breq", blit_breq, 1);
    m0 = n_mreq; cyc(10);
    chk("nogrant no mreq", n_mreq - m0, 0);
    blit_bgnt = 1'b1;
    check_job("slowack", 0, 32'h0);

    // STOP during the 3rd write of a 100-phrase fill.
    dly_lo = 1; dly_hi = 1;
    fill = {$urandom, $urandom};
    start_job(24'h0, 24'h5000, 100, 1, 0, 0, fill, 0, 1);
    k = 0;
    while (!(obsq.size() == 2 && mreq) && k < 300) begin cyc(1); k++; end
    chk("stop reached 3rd write", k < 300, 1);
    wr(3'd7, 32'h0);
    wait_idle("stop");
    build_exp(24'h0, 24'h5000, 3, 1, 0, 0, fill, 0);
    chk("stop xfer_count", obsq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < obsq.size(); i++)
      chk($sformatf("stop[%0d] addr", i), obsq[i].a, expq[i].a);
    chk("stop int_pulses", n_int, 1);
    rd_stat(3'd0, s); chk("stop status flags", s[31:29], 3'b001);
    rd_stat(3'd7, s); chk("stop status clr read", s[31:29], 3'b001);
    rd_stat(3'd0, s); chk("stop status cleared", s[31:29], 3'b000);

    // Zero count: DONE two cycles after CMD, no bus traffic.
    wr(3'd2, 32'h0005_0000);
    m0 = n_mreq; n_int = 0;
    wr(3'd6, 32'h2);
    chk("zero busy", busy, 1);      chk("zero int early", blit_int, 0);
    cyc(1); chk("zero int", blit_int, 1);
    cyc(1); chk("zero busy off", busy, 0); chk("zero int off", blit_int, 0);
    chk("zero no mreq", n_mreq - m0, 0);
    chk("zero int_pulses", n_int, 1);
    rd_stat(3'd0, s); chk("zero status", s, 32'h0000_0005);

    // CMD and config writes while busy are ignored and set err.
    start_job(24'h0, 24'h8000, 20, 1, 0, 0, 64'hCAFE_F00D_0000_0001, 0, 1);
    wr(3'd6, 32'h1);
    wr(3'd1, 32'h00AB_CDE8);
    check_job("busywr", 1, 32'h4000_0000);
    rd_stat(3'd7, s);
    rd_stat(3'd0, s); chk("err cleared", s, 32'h0);

    // Randomized jobs.
    for (int j = 0; j < 12; j++) begin
      mode = 1'($urandom_range(0, 1)); ie = 1'($urandom_range(0, 1));
      inner = $urandom_range(0, 9); outer = $urandom_range(0, 3);
      g_mode = $urandom_range(0, 1);
      if (g_mode == 0) blit_bgnt = 1'b1;
      dly_lo = 0; dly_hi = $urandom_range(0, 3);
      start_job({$urandom_range(0, 21'h1FFFFF), 3'b0}, {$urandom_range(0, 21'h1FFFFF), 3'b0},
                inner, outer, ($urandom_range(0, 16) - 8) * 8, ($urandom_range(0, 16) - 8) * 8,
                {$urandom, $urandom}, mode, ie);
      check_job($sformatf("rnd%0d", j), ie,
                (inner == 0 || outer == 0) ? 32'(outer) : 32'h0);
    end

    // Reset mid-copy.
    g_mode = 0; blit_bgnt = 1'b1; dly_lo = 1; dly_hi = 1;
    start_job(24'h6000, 24'h7000, 8, 2, 0, 0, 64'h0, 1, 1);
    k = 0;
    while (obsq.size() < 3 && k < 300) begin cyc(1); k++; end
    chk("midcopy reached", obsq.size() >= 3, 1);
    xreset_n = 1'b0; cyc(1); xreset_n = 1'b1;
    chk("midrst mreq", mreq, 0); chk("midrst breq", blit_breq, 0); chk("midrst busy", busy, 0);
    rd_stat(3'd0, s); chk("midrst status", s, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end
endmodule
